// File: rtl/sitcpxg_pkg.sv
// rtl/sitcpxg_pkg.sv - shared state encoding, TX_B constants and byte-swap helper for the SiTCPXG TX path
package sitcpxg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        CLOSE = 2'd2
    } state_e;

    localparam logic [3:0] TX_B_FULL = 4'd8;
    localparam logic [3:0] TX_B_NONE = 4'd0;

    // Byte 0 of the source word lands in bits [63:56] of the result.
    function automatic logic [63:0] byte_swap64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = d[8*(7-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sitcpxg_tx_arbiter_rr_arbiter.sv
// rtl/sitcpxg_tx_arbiter_rr_arbiter.sv - combinational round-robin picker: first request at or after the pointer
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   gnt_o,
    output logic            any_o
);

    int            idx;
    logic [IW-1:0] idx_v;

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        gnt_o = '0;
        any_o = 1'b0;
        idx   = 0;
        idx_v = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_v = idx[IW-1:0];
            if (req_i[idx_v]) begin
                gnt_o = idx_v;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sitcpxg_tx_arbiter.sv
// rtl/sitcpxg_tx_arbiter.sv - round-robin bounded-burst arbiter feeding the SiTCPXG TCP TX port
module sitcpxg_tx_arbiter
    import sitcpxg_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 256,
    parameter int BYTE_SWAP = 1
) (
    input  logic               CLK156M,
    input  logic               CPU_RESET,
    input  logic               ENABLE,
    input  logic [NREQ-1:0]    REQ_VALID,
    input  logic [NREQ*64-1:0] REQ_DATA,
    output logic [NREQ-1:0]    REQ_READY,
    input  logic               TX_ESTABLISHED,
    input  logic               TX_AFULL,
    input  logic               TX_CLOSE_REQ,
    output logic               TX_CLOSE_ACK,
    output logic [63:0]        TX_D,
    output logic [3:0]         TX_B,
    output logic [2:0]         GRANT_ID,
    output logic [63:0]        WORD_COUNT
);

    localparam int          IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] LAST_BEAT = 16'(MAX_BURST - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [15:0]   burst_q, burst_d;
    logic [63:0]   tx_d_q, tx_d_d;
    logic [3:0]    tx_b_q, tx_b_d;
    logic [63:0]   wc_q, wc_d;
    logic          ack_q, ack_d;
    logic          en_q;

    logic [63:0]   req_word [NREQ];
    logic [IW-1:0] arb_gnt;
    logic          arb_any;
    logic          xfer_ok;
    logic          accept;
    logic [IW-1:0] next_ptr;
    logic [63:0]   out_word;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_word[i] = REQ_DATA[64*i +: 64];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req_i (REQ_VALID),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .any_o (arb_any)
    );

    assign xfer_ok  = (state_q == XFER) & ENABLE & TX_ESTABLISHED & ~TX_AFULL & ~TX_CLOSE_REQ;
    assign accept   = xfer_ok & REQ_VALID[grant_q];
    assign next_ptr = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
    assign out_word = (BYTE_SWAP != 0) ? byte_swap64(req_word[grant_q]) : req_word[grant_q];

    always_comb begin
        REQ_READY = '0;
        if (xfer_ok) begin
            REQ_READY[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        tx_b_d  = accept ? TX_B_FULL : TX_B_NONE;
        tx_d_d  = accept ? out_word : tx_d_q;
        if (ENABLE && !en_q) begin
            wc_d = '0;
        end else if (accept) begin
            wc_d = wc_q + 64'd1;
        end else begin
            wc_d = wc_q;
        end

        unique case (state_q)
            IDLE: begin
                if (TX_CLOSE_REQ) begin
                    state_d = CLOSE;
                end else if (ENABLE && TX_ESTABLISHED && arb_any) begin
                    state_d = XFER;
                    grant_d = arb_gnt;
                    burst_d = '0;
                end
            end
            XFER: begin
                if (TX_CLOSE_REQ) begin
                    state_d = CLOSE;
                end else if (!TX_ESTABLISHED || !ENABLE) begin
                    state_d = IDLE;
                end else if (accept) begin
                    if (burst_q == LAST_BEAT) begin
                        state_d = IDLE;
                        ptr_d   = next_ptr;
                    end else begin
                        burst_d = burst_q + 16'd1;
                    end
                end else if (!REQ_VALID[grant_q]) begin
                    // Requester went away; hand the turn on without emitting anything.
                    state_d = IDLE;
                    ptr_d   = next_ptr;
                end
            end
            CLOSE: begin
                if (!TX_CLOSE_REQ) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ack_d = (state_d == CLOSE);
    end

    always_ff @(posedge CLK156M or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
            tx_d_q  <= '0;
            tx_b_q  <= TX_B_NONE;
            wc_q    <= '0;
            ack_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            tx_d_q  <= tx_d_d;
            tx_b_q  <= tx_b_d;
            wc_q    <= wc_d;
            ack_q   <= ack_d;
            en_q    <= ENABLE;
        end
    end

    assign TX_D         = tx_d_q;
    assign TX_B         = tx_b_q;
    assign TX_CLOSE_ACK = ack_q;
    assign WORD_COUNT   = wc_q;
    assign GRANT_ID     = 3'(grant_q);

endmodule

// File: tb/tb_sitcpxg_tx_arbiter.sv
// tb/tb_sitcpxg_tx_arbiter.sv - directed and randomized bench for sitcpxg_tx_arbiter against a behavioural model
module tb_sitcpxg_tx_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;

    logic            CLK156M = 1'b0;
    logic            CPU_RESET = 1'b0;
    logic            ENABLE = 1'b0;
    logic [N-1:0]    REQ_VALID = '0;
    logic [N*64-1:0] REQ_DATA = '0;
    logic [N-1:0]    REQ_READY;
    logic            TX_ESTABLISHED = 1'b0;
    logic            TX_AFULL = 1'b0;
    logic            TX_CLOSE_REQ = 1'b0;
    logic            TX_CLOSE_ACK;
    logic [63:0]     TX_D;
    logic [3:0]      TX_B;
    logic [2:0]      GRANT_ID;
    logic [63:0]     WORD_COUNT;

    always #5 CLK156M = ~CLK156M;

    sitcpxg_tx_arbiter #(
        .NREQ      (N),
        .MAX_BURST (MB),
        .BYTE_SWAP (1)
    ) dut (
        .CLK156M        (CLK156M),
        .CPU_RESET      (CPU_RESET),
        .ENABLE         (ENABLE),
        .REQ_VALID      (REQ_VALID),
        .REQ_DATA       (REQ_DATA),
        .REQ_READY      (REQ_READY),
        .TX_ESTABLISHED (TX_ESTABLISHED),
        .TX_AFULL       (TX_AFULL),
        .TX_CLOSE_REQ   (TX_CLOSE_REQ),
        .TX_CLOSE_ACK   (TX_CLOSE_ACK),
        .TX_D           (TX_D),
        .TX_B           (TX_B),
        .GRANT_ID       (GRANT_ID),
        .WORD_COUNT     (WORD_COUNT)
    );

    int tests = 0;
    int fails = 0;

    // Each source emits {index, running sequence number}; seq advances only on a handshake.
    logic [55:0] seq [N];

    // Model: m_grant < 0 means nobody holds the port; m_closing marks the close handshake.
    int          m_grant, m_ptr, m_burst, m_last_id;
    bit          m_closing, m_ack, m_en_prev;
    logic [63:0] m_tx_d, m_count;
    logic [3:0]  m_tx_b;

    function automatic logic [63:0] word_of(input int i, input logic [55:0] s);
        return {8'(i), s};
    endfunction

    function automatic logic [63:0] swap_bytes(input logic [63:0] w);
        logic [63:0] r;
        r = {<<8{w}};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < N; i++) begin
            REQ_DATA[64*i +: 64] = word_of(i, seq[i]);
        end
    endtask

    task automatic model_reset();
        m_grant   = -1;
        m_ptr     = 0;
        m_burst   = 0;
        m_last_id = 0;
        m_closing = 0;
        m_ack     = 0;
        m_en_prev = 0;
        m_tx_d    = '0;
        m_tx_b    = '0;
        m_count   = '0;
    endtask

    // Check outputs mid-cycle, advance the model over the coming edge, then step the clock.
    task automatic cycle();
        logic [N-1:0] exp_ready;
        bit           acc;
        int           g;
        @(negedge CLK156M);
        exp_ready = '0;
        if (m_grant >= 0 && ENABLE && TX_ESTABLISHED && !TX_AFULL && !TX_CLOSE_REQ) begin
            exp_ready[m_grant] = 1'b1;
        end
        chk("req_ready", 64'(REQ_READY), 64'(exp_ready));
        chk("tx_b", 64'(TX_B), 64'(m_tx_b));
        chk("tx_d", TX_D, m_tx_d);
        chk("grant_id", 64'(GRANT_ID), 64'(m_last_id));
        chk("word_count", WORD_COUNT, m_count);
        chk("close_ack", 64'(TX_CLOSE_ACK), 64'(m_ack));

        g   = m_grant;
        acc = (g >= 0) && exp_ready[g] && REQ_VALID[g];
        if (acc) begin
            m_tx_b = 4'd8;
            m_tx_d = swap_bytes(word_of(g, seq[g]));
        end else begin
            m_tx_b = 4'd0;
        end
        if (ENABLE && !m_en_prev) m_count = '0;
        else if (acc) m_count = m_count + 64'd1;
        m_en_prev = ENABLE;

        if (m_closing) begin
            if (!TX_CLOSE_REQ) begin
                m_closing = 0;
                m_ack     = 0;
            end
        end else if (g < 0) begin
            if (TX_CLOSE_REQ) begin
                m_closing = 1;
                m_ack     = 1;
            end else if (ENABLE && TX_ESTABLISHED && (REQ_VALID != 0)) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (REQ_VALID[(m_ptr + k) % N]) m_grant = (m_ptr + k) % N;
                end
                m_burst   = 0;
                m_last_id = m_grant;
            end
        end else begin
            if (TX_CLOSE_REQ) begin
                m_grant   = -1;
                m_closing = 1;
                m_ack     = 1;
            end else if (!TX_ESTABLISHED || !ENABLE) begin
                m_grant = -1;
            end else if (acc) begin
                m_burst++;
                if (m_burst == MB) begin
                    m_grant = -1;
                    m_ptr   = (g + 1) % N;
                end
            end else if (!REQ_VALID[g]) begin
                m_grant = -1;
                m_ptr   = (g + 1) % N;
            end
        end

        if (acc) seq[g] = seq[g] + 56'd1;
        @(posedge CLK156M);
        #1;
        drive_data();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic wait_burst(input int b);
        bit found;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_grant >= 0 && m_burst == b) found = 1;
            else cycle();
        end
        tests++;
        assert (found) else begin
            fails++;
            $error("FAIL wait_burst%0d obs=timeout exp=reached", b);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) seq[i] = '0;
        model_reset();
        drive_data();
        #1 CPU_RESET = 1'b1;
        @(posedge CLK156M);
        @(posedge CLK156M);
        #1;
        chk("rst_tx_b", 64'(TX_B), 64'd0);
        chk("rst_tx_d", TX_D, 64'd0);
        chk("rst_ready", 64'(REQ_READY), 64'd0);
        chk("rst_ack", 64'(TX_CLOSE_ACK), 64'd0);
        chk("rst_grant", 64'(GRANT_ID), 64'd0);
        chk("rst_wc", WORD_COUNT, 64'd0);

        // Single requester streaming.
        ENABLE         = 1'b1;
        TX_ESTABLISHED = 1'b1;
        REQ_VALID      = 4'b0001;
        CPU_RESET      = 1'b0;
        run(5);
        chk("wc_first_burst", WORD_COUNT, 64'd4);
        run(8);

        // All requesters valid: rotation 0,1,2,3,...
        REQ_VALID = 4'hF;
        run(40);

        // Backpressure after the first word of a burst.
        wait_burst(1);
        TX_AFULL = 1'b1;
        run(10);
        TX_AFULL = 1'b0;
        run(12);

        // Close handshake mid-burst, then re-establishment.
        wait_burst(1);
        TX_CLOSE_REQ = 1'b1;
        run(6);
        TX_CLOSE_REQ   = 1'b0;
        TX_ESTABLISHED = 1'b0;
        run(3);
        TX_ESTABLISHED = 1'b1;
        run(10);

        // Session drop mid-burst.
        wait_burst(2);
        TX_ESTABLISHED = 1'b0;
        run(4);
        TX_ESTABLISHED = 1'b1;
        run(8);

        // Asynchronous reset between clock edges during a burst.
        wait_burst(2);
        #2 CPU_RESET = 1'b1;
        #1;
        chk("arst_tx_b", 64'(TX_B), 64'd0);
        chk("arst_ack", 64'(TX_CLOSE_ACK), 64'd0);
        chk("arst_wc", WORD_COUNT, 64'd0);
        chk("arst_ready", 64'(REQ_READY), 64'd0);
        chk("arst_tx_d", TX_D, 64'd0);
        chk("arst_grant", 64'(GRANT_ID), 64'd0);
        model_reset();
        @(posedge CLK156M);
        @(posedge CLK156M);
        #1 CPU_RESET = 1'b0;
        run(20);

        // Randomized traffic with backpressure, session and enable changes.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) REQ_VALID[i] = ($urandom_range(0, 3) != 0);
            TX_AFULL = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) TX_ESTABLISHED = ~TX_ESTABLISHED;
            if ($urandom_range(0, 49) == 0) ENABLE = ~ENABLE;
            if ($urandom_range(0, 39) == 0) TX_CLOSE_REQ = ~TX_CLOSE_REQ;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sitcpxg_tx_arbiter.md
Name: sitcpxg_tx_arbiter

Overview:
- Shares the single SiTCPXG TCP TX port (64-bit data, byte-count qualifier) among NREQ user data sources, e.g. a counter generator and readout FIFOs.
- Uses round-robin arbitration with bounded bursts.
- Honours TX_AFULL backpressure and session state, and handles the close handshake.
- Sits between user stream sources and the SiTCPXG wrapper, in the CLK156M domain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_BURST, 256, max words per grant before re-arbitration (1..65535).
- BYTE_SWAP, 1, if 1, TX_D byte order is reversed (byte 0 of the requester word goes to TX_D[63:56]).

Ports:
- CLK156M  in  1  clock, 156.25 MHz.
- CPU_RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  global transmit enable, from a GPIO register bit.
- REQ_VALID  in  NREQ  per-requester word available.
- REQ_DATA  in  NREQ*64  per-requester word; requester i occupies bits [64i+63:64i].
- REQ_READY  out  NREQ  word accepted this cycle when VALID&READY.
- TX_ESTABLISHED  in  1  from SiTCPXG USER_SESSION_ESTABLISHED.
- TX_AFULL  in  1  from SiTCPXG USER_TX_AFULL.
- TX_CLOSE_REQ  in  1  from SiTCPXG USER_SESSION_CLOSE_REQ.
- TX_CLOSE_ACK  out  1  to USER_SESSION_CLOSE_ACK.
- TX_D  out  64  to USER_TX_D.
- TX_B  out  4  to USER_TX_B; 8 = valid word, 0 = none.
- GRANT_ID  out  3  index of the current or last grant.
- WORD_COUNT  out  64  total words sent since reset or since ENABLE rose.

Behaviour:
- Reset values: REQ_READY=0, TX_CLOSE_ACK=0, TX_D=0, TX_B=0, GRANT_ID=0, WORD_COUNT=0, state=IDLE, round-robin pointer=0, burst counter=0.
- Accept condition:
  - REQ_READY[i] = (state==XFER) & (grant==i) & ENABLE & TX_ESTABLISHED & !TX_AFULL & !TX_CLOSE_REQ.
  - REQ_READY is combinational from registered state plus those inputs. No other bit is ever high.
- Output pipeline, latency 1:
  - On accept, the next cycle has TX_D = the (swapped) word and TX_B = 8.
  - Every other cycle TX_B = 0 and TX_D holds its last value.
  - WORD_COUNT increments on each accept and wraps at 2^64.
  - A rising edge of ENABLE clears WORD_COUNT.
- State machine:
  - IDLE:
    - If ENABLE & TX_ESTABLISHED & !TX_CLOSE_REQ and any REQ_VALID is set, grant the first valid index at or after the pointer, searching cyclically.
    - Load grant and GRANT_ID, clear the burst counter, go to XFER.
    - The earliest accept is the cycle after the grant.
  - XFER, exit conditions in priority order:
    - TX_CLOSE_REQ -> CLOSE.
    - !TX_ESTABLISHED or !ENABLE -> IDLE.
    - Accept with burst counter == MAX_BURST-1 -> IDLE; pointer = grant+1 mod NREQ.
    - REQ_VALID[grant]==0 for a cycle -> IDLE; pointer = grant+1 mod NREQ.
  - TX_AFULL high in XFER: hold the grant; burst counter frozen; no timeout.
  - CLOSE:
    - TX_CLOSE_ACK=1 from the cycle after entry while TX_CLOSE_REQ stays high. The pipeline word from the entry cycle has already been presented.
    - When TX_CLOSE_REQ falls: TX_CLOSE_ACK=0 next cycle, go to IDLE, pointer unchanged.
  - TX_CLOSE_REQ seen in IDLE also goes to CLOSE.
- Boundary cases:
  - Simultaneous valids: only the pointer-selected requester is served.
  - NREQ=1: the pointer is constant.
  - A requester dropping VALID mid-burst loses its grant; no bubble word is emitted.
  - CPU_RESET mid-burst: all outputs go to reset values immediately (async). The in-flight word is dropped.
  - MAX_BURST=1: each accept re-arbitrates, giving a fixed 2-cycle period per word.

Decomposition:
- Shared package sitcpxg_pkg holds:
  - state encoding IDLE=2'd0, XFER=2'd1, CLOSE=2'd2;
  - constant TX_B_FULL=4'd8;
  - a byte-swap function.
- Sub-module rr_arbiter (NREQ, req vector, pointer in, grant index plus any-grant out) is combinational and reusable for other shared resources.

Test Plan:
- Single requester: ENABLE=1, ESTABLISHED=1, req0 streams 0,1,2… with MAX_BURST=4.
  - Grant next cycle; TX_B=8 for 4 cycles, then a 1-cycle gap, then a regrant.
  - TX_D = byte-swapped 0..3; WORD_COUNT=4 after the first burst.
- All 4 requesters valid, MAX_BURST=2:
  - Grants go 0,1,2,3,0…, with exactly 2 words each per grant.
  - No REQ_READY overlap.
- TX_AFULL high 10 cycles mid-burst (word 1 of 4):
  - REQ_READY=0 and TX_B=0 during the stall.
  - Grant held; the remaining 3 words follow the stall, with no loss or duplication.
- TX_CLOSE_REQ asserted mid-burst:
  - At most one word after the assertion edge.
  - TX_CLOSE_ACK=1 while CLOSE_REQ is high, 0 one cycle after it falls.
  - Transfers resume only after re-establishment.
- ESTABLISHED drops mid-burst: next cycle REQ_READY=0, TX_B=0, state IDLE, WORD_COUNT frozen.
- CPU_RESET pulsed during a transfer: TX_B=0, TX_CLOSE_ACK=0, WORD_COUNT=0 asynchronously; normal service resumes after release.
